// File: rtl/ad9361_spi_master.sv
// SPI master for AD9361 register access.
// Each frame is a 16-bit instruction followed by 1..MAX_BYTES data bytes.
// SCLK is a registered CPOL=0 clock, divided from sys_clk by 2*CLK_DIV.
module ad9361_spi_master #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned MAX_BYTES = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr_rdn,
  input  logic [9:0]             cmd_addr,
  input  logic [2:0]             cmd_nbytes,
  input  logic [8*MAX_BYTES-1:0] cmd_wdata,
  output logic                   rsp_valid,
  output logic [8*MAX_BYTES-1:0] rsp_rdata,
  output logic                   busy,
  output logic                   spi_cs_n,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  localparam int unsigned DataW  = 8 * MAX_BYTES;
  localparam int unsigned FrameW = 16 + DataW;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RxIdxW = $clog2(DataW);

  localparam logic [2:0]      MaxNbm1   = 3'(MAX_BYTES - 1);
  localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivPenult = DivW'(CLK_DIV - 2);

  typedef enum logic [1:0] {StIdle, StShift, StHold, StGap} state_e;

  state_e              state_q;
  logic [DivW-1:0]     div_q;
  logic [6:0]          bit_cnt_q;
  logic [6:0]          last_q;
  logic                wr_q;
  logic [FrameW-1:0]   tx_q;
  logic [DataW-1:0]    rx_q;

  logic                accept;
  logic [2:0]          nbm1;
  logic [15:0]         instr;
  logic [FrameW-1:0]   frame;
  logic [6:0]          d_idx;
  logic [RxIdxW-1:0]   rx_pos;

  assign accept = cmd_valid & cmd_ready;
  assign busy   = ~cmd_ready;

  // Oversized byte counts are clamped to the payload width.
  assign nbm1  = (cmd_nbytes > MaxNbm1) ? MaxNbm1 : cmd_nbytes;
  assign instr = {cmd_wr_rdn, nbm1, 2'b00, cmd_addr};

  // Received data bit d lands MSB-first in byte d/8: position 8*(d/8) + 7 - d%8.
  assign d_idx  = bit_cnt_q - 7'd16;
  assign rx_pos = RxIdxW'({d_idx[6:3], ~d_idx[2:0]});

  // Assemble the outgoing frame MSB-aligned; reads send zeros after the instruction.
  always_comb begin
    frame = '0;
    frame[FrameW-1 -: 16] = instr;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (cmd_wr_rdn && (i <= 32'(nbm1))) begin
        frame[DataW-1-8*i -: 8] = cmd_wdata[8*i +: 8];
      end
    end
  end

  // Transaction FSM with divider, bit counter, shift registers and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_cnt_q <= '0;
      last_q    <= '0;
      wr_q      <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        state_q   <= StShift;
        div_q     <= '0;
        bit_cnt_q <= '0;
        // Index of the final bit: N - 1 = 16 + 8*nb - 1.
        last_q    <= 7'd23 + {1'b0, nbm1, 3'b000};
        wr_q      <= cmd_wr_rdn;
        tx_q      <= frame;
        rx_q      <= '0;
        cmd_ready <= 1'b0;
        spi_cs_n  <= 1'b0;
        spi_sclk  <= 1'b0;
        spi_mosi  <= frame[FrameW-1];
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StShift: begin
            if (div_q == DivLast) begin
              div_q <= '0;
              if (!spi_sclk) begin
                spi_sclk <= 1'b1;
                if (bit_cnt_q >= 7'd16) begin
                  rx_q[rx_pos] <= spi_miso;
                end
              end else begin
                spi_sclk <= 1'b0;
                tx_q     <= {tx_q[FrameW-2:0], 1'b0};
                spi_mosi <= tx_q[FrameW-2];
                if (bit_cnt_q == last_q) begin
                  state_q <= StHold;
                end else begin
                  bit_cnt_q <= bit_cnt_q + 7'd1;
                end
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          StHold: begin
            if (div_q == DivLast) begin
              div_q     <= '0;
              state_q   <= StGap;
              spi_cs_n  <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_rdata <= wr_q ? '0 : rx_q;
              // With a one-cycle gap the next command may be taken on the following edge.
              if (CLK_DIV == 1) begin
                cmd_ready <= 1'b1;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          StGap: begin
            if (div_q == DivLast) begin
              state_q <= StIdle;
            end else begin
              div_q <= div_q + 1'b1;
              // Ready during the last gap cycle so a held command starts right as the gap ends.
              if (div_q == DivPenult) begin
                cmd_ready <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad9361_spi_master.sv
// Directed bench for ad9361_spi_master: three instances (CLK_DIV/MAX_BYTES = 2/4, 2/2, 1/4)
// share command inputs, a muxed SPI slave model and a muxed output monitor.
module tb_ad9361_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vld = '0;
  logic        cmd_wr_rdn = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [2:0]  cmd_nbytes = '0;
  logic [31:0] cmd_wdata = '0;
  logic        spi_miso;
  logic [1:0]  sel = 2'd0;

  logic        rdy_a, rv_a, busy_a, cs_a, sclk_a, mosi_a;
  logic        rdy_b, rv_b, busy_b, cs_b, sclk_b, mosi_b;
  logic        rdy_c, rv_c, busy_c, cs_c, sclk_c, mosi_c;
  logic [31:0] rd_a, rd_c;
  logic [15:0] rd_b;

  always #5 clk = ~clk;

  ad9361_spi_master #(.CLK_DIV(2), .MAX_BYTES(4)) u_a (
    .sys_clk(clk), .sys_rst(rst), .cmd_valid(vld[0]), .cmd_ready(rdy_a),
    .cmd_wr_rdn(cmd_wr_rdn), .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes),
    .cmd_wdata(cmd_wdata), .rsp_valid(rv_a), .rsp_rdata(rd_a), .busy(busy_a),
    .spi_cs_n(cs_a), .spi_sclk(sclk_a), .spi_mosi(mosi_a), .spi_miso(spi_miso)
  );

  ad9361_spi_master #(.CLK_DIV(2), .MAX_BYTES(2)) u_b (
    .sys_clk(clk), .sys_rst(rst), .cmd_valid(vld[1]), .cmd_ready(rdy_b),
    .cmd_wr_rdn(cmd_wr_rdn), .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes),
    .cmd_wdata(cmd_wdata[15:0]), .rsp_valid(rv_b), .rsp_rdata(rd_b), .busy(busy_b),
    .spi_cs_n(cs_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b), .spi_miso(spi_miso)
  );

  ad9361_spi_master #(.CLK_DIV(1), .MAX_BYTES(4)) u_c (
    .sys_clk(clk), .sys_rst(rst), .cmd_valid(vld[2]), .cmd_ready(rdy_c),
    .cmd_wr_rdn(cmd_wr_rdn), .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes),
    .cmd_wdata(cmd_wdata), .rsp_valid(rv_c), .rsp_rdata(rd_c), .busy(busy_c),
    .spi_cs_n(cs_c), .spi_sclk(sclk_c), .spi_mosi(mosi_c), .spi_miso(spi_miso)
  );

  // Selected instance's outputs.
  logic        m_cs, m_sclk, m_mosi, m_rv, m_rdy, m_busy;
  logic [31:0] m_rd;
  assign m_cs   = (sel == 2'd0) ? cs_a   : (sel == 2'd1) ? cs_b   : cs_c;
  assign m_sclk = (sel == 2'd0) ? sclk_a : (sel == 2'd1) ? sclk_b : sclk_c;
  assign m_mosi = (sel == 2'd0) ? mosi_a : (sel == 2'd1) ? mosi_b : mosi_c;
  assign m_rv   = (sel == 2'd0) ? rv_a   : (sel == 2'd1) ? rv_b   : rv_c;
  assign m_rdy  = (sel == 2'd0) ? rdy_a  : (sel == 2'd1) ? rdy_b  : rdy_c;
  assign m_busy = (sel == 2'd0) ? busy_a : (sel == 2'd1) ? busy_b : busy_c;
  assign m_rd   = (sel == 2'd0) ? rd_a   : (sel == 2'd1) ? {16'h0, rd_b} : rd_c;

  // Slave model: counts rising SCLK edges, captures MOSI, drives MISO for data bits.
  logic [6:0]  cnt = '0;
  logic [79:0] mosi_cap = '0;
  logic [63:0] miso_pat = '0;
  logic [6:0]  miso_d;
  always @(posedge m_sclk or negedge m_cs) begin
    if (m_sclk) begin
      cnt      <= cnt + 7'd1;
      mosi_cap <= {mosi_cap[78:0], m_mosi};
    end else begin
      cnt      <= '0;
      mosi_cap <= '0;
    end
  end
  assign miso_d   = cnt - 7'd16;
  assign spi_miso = (cnt >= 7'd16) ? miso_pat[{miso_d[5:3], ~miso_d[2:0]}] : 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rsp_cnt = 0;
  int sclk_bad = 0;
  always @(negedge clk) begin
    if (m_rv) rsp_cnt <= rsp_cnt + 1;
    if (m_cs && m_sclk) sclk_bad <= sclk_bad + 1;
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cs(input logic level, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (m_cs === level) begin
        at = cyc;
        break;
      end
    end
    chk("cs_wait", 80'(at >= 0), 80'd1);
  endtask

  task automatic wait_rsp(input int bound, output int at, output logic [31:0] data);
    at = -1;
    data = '0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (m_rv === 1'b1) begin
        at = cyc;
        data = m_rd;
        break;
      end
    end
    chk("rsp_wait", 80'(at >= 0), 80'd1);
  endtask

  task automatic issue(input logic [1:0] s, input logic wr, input logic [9:0] addr,
                       input logic [2:0] nb, input logic [31:0] wd, output int k);
    @(negedge clk);
    sel        = s;
    cmd_wr_rdn = wr;
    cmd_addr   = addr;
    cmd_nbytes = nb;
    cmd_wdata  = wd;
    vld[s]     = 1'b1;
    wait_cs(1'b0, 20, k);
    vld = '0;
  endtask

  int k, at, r1, k2, n0;
  logic [31:0] d;

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_cs_n", m_cs, 1);
    chk("rst_sclk", m_sclk, 0);
    chk("rst_mosi", m_mosi, 0);
    chk("rst_ready", m_rdy, 1);
    chk("rst_busy", m_busy, 0);
    chk("rst_rsp_valid", m_rv, 0);
    chk("rst_rdata", m_rd, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single-byte write: 0x83F45A, rsp at k+98, ready at k+100.
    issue(2'd0, 1'b1, 10'h3F4, 3'd0, 32'h5A, k);
    chk("wr1_busy", m_busy, 1);
    chk("wr1_ready", m_rdy, 0);
    chk("wr1_mosi0", m_mosi, 1);
    wait_rsp(200, at, d);
    chk("wr1_rsp_lat", 80'(at - k), 80'd98);
    chk("wr1_rdata", d, 0);
    chk("wr1_cs_rise", m_cs, 1);
    chk("wr1_ready_at_rsp", m_rdy, 0);
    chk("wr1_edges", cnt, 24);
    chk("wr1_mosi", mosi_cap[23:0], 24'h83F45A);
    @(negedge clk);
    chk("wr1_rsp_pulse", m_rv, 0);
    @(negedge clk);
    chk("wr1_ready_k100", m_rdy, 1);
    chk("wr1_busy_k100", m_busy, 0);

    // 4-byte read: instruction 0x3037, 48 edges.
    miso_pat = 64'h44332211;
    issue(2'd0, 1'b0, 10'h037, 3'd3, 32'hFFFFFFFF, k);
    wait_rsp(400, at, d);
    chk("rd4_rsp_lat", 80'(at - k), 80'd194);
    chk("rd4_rdata", d, 32'h44332211);
    chk("rd4_edges", cnt, 48);
    chk("rd4_mosi", mosi_cap[47:0], {16'h3037, 32'h0});
    repeat (5) @(negedge clk);
    chk("rd4_rdata_hold", m_rd, 32'h44332211);

    // Back-to-back writes with cmd_valid held.
    n0 = rsp_cnt;
    @(negedge clk);
    sel = 2'd0;
    cmd_wr_rdn = 1'b1;
    cmd_addr = 10'h010;
    cmd_nbytes = 3'd0;
    cmd_wdata = 32'h11;
    vld[0] = 1'b1;
    wait_cs(1'b0, 20, k);
    cmd_addr = 10'h020;
    cmd_nbytes = 3'd1;
    cmd_wdata = 32'hBBAA;
    wait_cs(1'b1, 200, r1);
    wait_cs(1'b0, 20, k2);
    vld = '0;
    chk("b2b_gap", 80'(k2 - r1), 80'd2);
    wait_rsp(300, at, d);
    chk("b2b_rsp_lat", 80'(at - k2), 80'd130);
    chk("b2b_rdata_zero", d, 0);
    chk("b2b_edges", cnt, 32);
    chk("b2b_mosi", mosi_cap[31:0], 32'h9020AABB);
    repeat (10) @(negedge clk);
    chk("b2b_rsp_count", 80'(rsp_cnt - n0), 80'd2);

    // Reset at the 10th rising SCLK edge.
    miso_pat = 64'hFFFFFFFF;
    issue(2'd0, 1'b0, 10'h155, 3'd0, 32'h0, k);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (cnt == 7'd10) break;
    end
    chk("rst_mid_edge", cnt, 10);
    n0 = rsp_cnt;
    rst = 1'b1;
    #1;
    chk("rst_mid_cs_n", m_cs, 1);
    chk("rst_mid_sclk", m_sclk, 0);
    chk("rst_mid_busy", m_busy, 0);
    chk("rst_mid_ready", m_rdy, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_rsp", 80'(rsp_cnt - n0), 80'd0);
    chk("rst_mid_rdata", m_rd, 0);
    issue(2'd0, 1'b1, 10'h001, 3'd0, 32'hC3, k);
    wait_rsp(200, at, d);
    chk("rst_after_lat", 80'(at - k), 80'd98);
    chk("rst_after_edges", cnt, 24);
    chk("rst_after_mosi", mosi_cap[23:0], 24'h8001C3);

    // Clamp: MAX_BYTES=2, nbytes=7 -> count field 1, 32-bit frame.
    repeat (4) @(negedge clk);
    miso_pat = 64'h3CA5;
    issue(2'd1, 1'b0, 10'h155, 3'd7, 32'h0, k);
    wait_rsp(300, at, d);
    chk("clamp_rsp_lat", 80'(at - k), 80'd130);
    chk("clamp_rdata", d, 32'h3CA5);
    chk("clamp_edges", cnt, 32);
    chk("clamp_mosi", mosi_cap[31:0], 32'h11550000);

    // CLK_DIV=1, 1-byte read: rsp at k+49.
    repeat (4) @(negedge clk);
    miso_pat = 64'h96;
    issue(2'd2, 1'b0, 10'h2C1, 3'd0, 32'h0, k);
    wait_rsp(100, at, d);
    chk("div1_rsp_lat", 80'(at - k), 80'd49);
    chk("div1_rdata", d, 32'h96);
    chk("div1_edges", cnt, 24);
    chk("div1_mosi", mosi_cap[23:0], 24'h02C100);
    repeat (3) @(negedge clk);
    chk("div1_ready", m_rdy, 1);

    chk("sclk_low_when_cs_high", sclk_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ad9361_spi_master.md
# ad9361_spi_master

Parametrised SPI master for AD9361 register access. It supports multi-byte (1–8 byte) streaming transfers, a programmable SCLK divider, and a registered (non-gated) SCLK. It accepts register commands over a valid/ready handshake from the configuration sequencer. It returns read data with a one-cycle response strobe. It replaces the fixed single-byte, full-rate driver in the radio configuration path.

## Interface
Parameters:
- CLK_DIV, 2: sys_clk cycles per SCLK half-period; legal values ≥1.
- MAX_BYTES, 4: largest data payload per transaction; legal values 1..8.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command; reset value 1.
- cmd_wr_rdn  in  1  1 = write, 0 = read.
- cmd_addr  in  10  register address (first byte).
- cmd_nbytes  in  3  byte count minus one.
- cmd_wdata  in  8*MAX_BYTES  write payload; byte i is bits [8i+7:8i], and byte 0 is sent first.
- rsp_valid  out  1  one-cycle completion pulse, issued for both reads and writes; reset value 0.
- rsp_rdata  out  8*MAX_BYTES  read payload; byte i is the i-th byte received. Holds its value until the next rsp_valid. Reset value 0.
- busy  out  1  asserted while a transaction is in progress (= ~cmd_ready); reset value 0.
- spi_cs_n  out  1  chip select, active-low; reset value 1.
- spi_sclk  out  1  SPI clock, CPOL=0, registered; reset value 0.
- spi_mosi  out  1  master data out; reset value 0.
- spi_miso  in  1  slave data out.

## Operation
- A command is accepted on a sys_clk edge where cmd_valid & cmd_ready. All cmd_* inputs are captured at that edge, and cmd_ready drops at the same edge.
- Effective byte count: nb = min(cmd_nbytes, MAX_BYTES-1) + 1. Out-of-range values are clamped silently.
- Instruction word: {cmd_wr_rdn, nb-1 (3 bits), 2'b00, cmd_addr}. It is sent MSB first.
- Frame length: N = 16 + 8*nb bits.
- Write frame: the instruction, followed by bytes 0..nb-1 of cmd_wdata, each byte MSB first.
- Read frame: the instruction, followed by 8*nb zero bits on MOSI. MISO is sampled for the data bits only.
- Received bits are shifted MSB first into byte positions 0..nb-1. Bytes ≥ nb of rsp_rdata are 0.
- On a write, rsp_rdata is set to all zeros at rsp_valid.
- FSM states:
  - IDLE: cs_n=1, ready=1. Goes to SHIFT on accept.
  - SHIFT: toggles sclk every CLK_DIV cycles until the N-th falling edge, then goes to HOLD.
  - HOLD: lasts CLK_DIV cycles with cs_n=0 and sclk=0, then goes to GAP, raising cs_n and pulsing rsp_valid.
  - GAP: lasts CLK_DIV cycles with cs_n=1, then returns to IDLE.
- Bit/edge rules: MOSI changes only at the accept edge or on SCLK falling edges. MISO is sampled on the sys_clk edge that drives SCLK high.
- Reset at any point forces all outputs to their reset values immediately. The in-flight transaction is abandoned: no rsp_valid is issued, and no partial rsp_rdata update occurs.
- cmd_valid deasserting mid-transaction has no effect. Command inputs are don't-care while busy.

## Timing
Let accept edge = k.
- k: cs_n→0, mosi = bit N-1, busy→1.
- Rising edge of bit j (j=0..N-1) at k+(2j+1)·CLK_DIV, where j=0 is the MSB. MISO is sampled at the same edge.
- Falling edge after bit j at k+(2j+2)·CLK_DIV. MOSI is updated to the next bit at that edge.
- k+(2N+1)·CLK_DIV: cs_n→1, rsp_valid=1 for one cycle, rsp_rdata valid.
- k+(2N+2)·CLK_DIV: cmd_ready→1. A command held on cmd_valid is accepted at this edge, giving back-to-back frames with CS high for exactly CLK_DIV cycles.
- Exactly N rising SCLK edges occur per frame. SCLK is 0 whenever cs_n=1.

## Test plan
- Single-byte write, CLK_DIV=2, addr 0x3F4, data 0x5A, nbytes 0 → MOSI sequence 0x83F45A (24 rising edges). rsp_valid at k+98, rsp_rdata=0, cmd_ready at k+100.
- 4-byte read, addr 0x037, nbytes 3, MISO model returns 0x11,0x22,0x33,0x44 → instruction 0x3037, 48 rising edges, rsp_rdata[31:0]=0x44332211.
- Back-to-back: cmd_valid held high for two writes → second cs_n fall exactly CLK_DIV cycles after the first cs_n rise, and exactly two rsp_valid pulses.
- Clamp: MAX_BYTES=2, nbytes=7 → instruction count field = 1, 32-bit frame, rsp_rdata[15:8] holds the second received byte.
- Reset asserted at the 10th rising SCLK edge → cs_n=1, sclk=0, busy=0, cmd_ready=1 immediately. No rsp_valid. The next command after release runs a complete frame.
- CLK_DIV=1, 1-byte read → SCLK = sys_clk/2, rsp_valid at k+49, MISO bits land correctly.
